// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core constants plus the UART TX register map,
// STATUS bit positions and FSM state type (PARITY only with UART_TX_PARITY_EN).
package riscv_pkg;

    localparam int MMCM_OUT_FREQ_MHZ = 300;
    localparam int NB_COL            = 4;
    localparam int COL_WIDTH         = 8;

    localparam int UART_BAUD = 115200;
    localparam int UART_CLKS_PER_BIT =
        MMCM_OUT_FREQ_MHZ * 1_000_000 / UART_BAUD;

    localparam int UART_TXDATA_ADDR = 0;
    localparam int UART_STATUS_ADDR = 1;

    localparam int UART_ST_FULL      = 0;
    localparam int UART_ST_EMPTY     = 1;
    localparam int UART_ST_BUSY      = 2;
    localparam int UART_ST_OVF       = 3;
    localparam int UART_ST_PARITY    = 4;
    localparam int UART_ST_COUNT_LSB = 8;
    localparam int UART_ST_COUNT_W   = 8;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_STOP   = 3'd3,
        UART_PARITY = 3'd4
    } uart_tx_state_t;
`else
    typedef enum logic [2:0] {
        UART_IDLE  = 3'd0,
        UART_START = 3'd1,
        UART_DATA  = 3'd2,
        UART_STOP  = 3'd3
    } uart_tx_state_t;
`endif

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with extra-MSB pointers and occupancy count.
// Ports: clk, reset_n, push, pop, din, dout (head, comb), full, empty, count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

    // A pop in the same cycle frees the slot a full push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: MMIO UART transmitter; TXDATA push / STATUS poll, 8N1 line.
// Ports: clk, reset_n, mmio_* load/store port, tx, tx_busy, irq_empty.
// UART_TX_PARITY_EN adds an even-parity bit before STOP (11-bit frame).
import riscv_pkg::*;

module mmio_uart_tx #(
    parameter int CLKS_PER_BIT   = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH     = 16,
    parameter int REG_ADDR_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          mmio_sel,
    input  logic                          mmio_we,
    input  logic [REG_ADDR_WIDTH-1:0]     mmio_addr,
    input  logic [NB_COL*COL_WIDTH-1:0]   mmio_wdata,
    input  logic [NB_COL-1:0]             mmio_be,
    output logic [NB_COL*COL_WIDTH-1:0]   mmio_rdata,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          irq_empty
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    logic rst_meta;
    logic rst_n_int;

    logic           wr_acc;
    logic           rd_acc;
    logic           is_txdata;
    logic           is_status;
    logic           push;
    logic           ovf_clr;
    logic           ovf;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_dout;
    logic [CW-1:0]  fifo_count;
    logic [31:0]    status;

    uart_tx_state_t state;
    logic [BW-1:0]  baud;
    logic           baud_last;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;

    logic unused_ok;
    assign unused_ok = ^{mmio_wdata[31:8], mmio_be[3:1]};

    // Assert asynchronously, release two clocks after reset_n rises.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_meta  <= 1'b0;
            rst_n_int <= 1'b0;
        end else begin
            rst_meta  <= 1'b1;
            rst_n_int <= rst_meta;
        end
    end

    assign wr_acc    = mmio_sel && mmio_we;
    assign rd_acc    = mmio_sel && !mmio_we;
    assign is_txdata =
        (mmio_addr == REG_ADDR_WIDTH'(UART_TXDATA_ADDR));
    assign is_status =
        (mmio_addr == REG_ADDR_WIDTH'(UART_STATUS_ADDR));
    assign push      = wr_acc && is_txdata && mmio_be[0];
    assign ovf_clr   = wr_acc && is_status && mmio_be[0] &&
                       mmio_wdata[UART_ST_OVF];

    assign baud_last = (baud == BAUD_LAST);
    assign fifo_pop  = !fifo_empty &&
                       ((state == UART_IDLE) ||
                        ((state == UART_STOP) && baud_last));

    assign tx_busy   = (state != UART_IDLE) || !fifo_empty;
    assign irq_empty = !tx_busy;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (rst_n_int),
        .push    (push),
        .pop     (fifo_pop),
        .din     (mmio_wdata[7:0]),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        status = '0;
        status[UART_ST_FULL]   = fifo_full;
        status[UART_ST_EMPTY]  = fifo_empty;
        status[UART_ST_BUSY]   = tx_busy;
        status[UART_ST_OVF]    = ovf;
        status[UART_ST_PARITY] = PARITY_EN;
        status[UART_ST_COUNT_LSB +: UART_ST_COUNT_W] =
            UART_ST_COUNT_W'(fifo_count);
    end

    // Loads see pre-access state; only STATUS reads non-zero.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            mmio_rdata <= '0;
        end else begin
            mmio_rdata <= (rd_acc && is_status) ? status : '0;
        end
    end

    // A dropped push is a full FIFO with no pop freeing a slot.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            ovf <= 1'b0;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end else if (push && fifo_full && !fifo_pop) begin
            ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state   <= UART_IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
        end else begin
            unique case (state)
                UART_IDLE: begin
                    if (fifo_pop) begin
                        shreg <= fifo_dout;
                        baud  <= '0;
                        tx    <= 1'b0;
                        state <= UART_START;
                    end
                end
                UART_START: begin
                    if (baud_last) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        tx      <= shreg[0];
                        state   <= UART_DATA;
                    end else begin
                        baud <= baud + BAUD_ONE;
                    end
                end
                UART_DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= ^shreg;
                            state <= UART_PARITY;
`else
                            tx    <= 1'b1;
                            state <= UART_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        baud <= baud + BAUD_ONE;
                    end
                end
`ifdef UART_TX_PARITY_EN
                UART_PARITY: begin
                    if (baud_last) begin
                        baud  <= '0;
                        tx    <= 1'b1;
                        state <= UART_STOP;
                    end else begin
                        baud <= baud + BAUD_ONE;
                    end
                end
`endif
                UART_STOP: begin
                    if (baud_last) begin
                        baud <= '0;
                        // Chain straight into the next start bit.
                        if (fifo_pop) begin
                            shreg <= fifo_dout;
                            tx    <= 1'b0;
                            state <= UART_START;
                        end else begin
                            state <= UART_IDLE;
                        end
                    end else begin
                        baud <= baud + BAUD_ONE;
                    end
                end
                default: begin
                    state <= UART_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
